// File: rtl/mem_loader_if.sv
// mem_loader_if: bundles the host byte stream and the shared memory write
// port of the boot loader.
//   in_valid/in_data/in_ready : host byte handshake (byte moves when valid & ready)
//   mem_addr/mem_wdata        : write address/data shared by both memories
//   im_we/dm_we               : instruction-/data-memory write strobes
//   busy                      : a frame is in progress
//   cores_run                 : release for all cores after the final frame
// Modports: master = host/memory side, slave = the loader itself.
interface mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              im_we;
    logic              dm_we;
    logic              busy;
    logic              cores_run;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_wdata, im_we, dm_we, busy, cores_run
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_wdata, im_we, dm_we, busy, cores_run
    );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: receives framed bytes from a host and writes them into the
// instruction or data memory, then releases the cores after the last frame.
// Frame: header (bit7 target 0=IM/1=DM, bit6 last frame), start address,
// word count (0 means 256), then one byte per word, zero-extended to DATA_W.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_loader_if.slave (host handshake + shared memory write port)
module mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              target_r;
    logic              last_r;
    logic [ADDR_W-1:0] addr_r;
    logic [8:0]        cnt_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              im_we_r;
    logic              dm_we_r;
    logic              busy_r;
    logic              cores_run_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              data_accept_s;
    logic              final_s;

    // Ready depends on the state only; DONE swallows nothing.
    assign in_ready_s    = (state_r != DONE);
    assign accept_s      = bus.in_valid & in_ready_s;
    assign data_accept_s = accept_s & (state_r == DATA);
    assign final_s       = (cnt_r == 9'd1);

    // Next-state decode; every state advances only on an accepted byte.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            case (state_r)
                HDR:     state_nxt_s = ADDR;
                ADDR:    state_nxt_s = LEN;
                LEN:     state_nxt_s = DATA;
                DATA: begin
                    if (final_s) begin
                        state_nxt_s = last_r ? DONE : HDR;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
                DONE:    state_nxt_s = DONE;
                default: state_nxt_s = HDR;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HDR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame context: target, last flag, running address and remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= 1'b0;
            last_r   <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            cnt_r    <= 9'd0;
        end else if (accept_s) begin
            case (state_r)
                HDR: begin
                    target_r <= bus.in_data[7];
                    last_r   <= bus.in_data[6];
                end
                ADDR:    addr_r <= ADDR_W'(bus.in_data);
                // A zero count stands for a full 256-word frame.
                LEN:     cnt_r <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                DATA: begin
                    // Natural modulo-2^ADDR_W wrap.
                    addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    cnt_r  <= cnt_r - 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Write port: one-cycle strobe after each accepted data byte; address and
    // data registered on the same edge and held until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we_r     <= 1'b0;
            dm_we_r     <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            im_we_r <= data_accept_s & ~target_r;
            dm_we_r <= data_accept_s &  target_r;
            if (data_accept_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= DATA_W'(bus.in_data);
            end
        end
    end

    // Status: busy tracks the mid-frame states; cores_run follows DONE one
    // cycle later so it rises after the final write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            cores_run_r <= 1'b0;
        end else begin
            busy_r      <= (state_nxt_s == ADDR) || (state_nxt_s == LEN) ||
                           (state_nxt_s == DATA);
            cores_run_r <= (state_r == DONE);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.im_we     = im_we_r;
    assign bus.dm_we     = dm_we_r;
    assign bus.busy      = busy_r;
    assign bus.cores_run = cores_run_r;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader.
module tb_mem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          dm;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t wr_q[$];

    // Reference frame model: 0=HDR 1=ADDR 2=LEN 3=DATA 4=DONE
    int m_state;
    bit m_last;
    int m_cnt;
    bit m_run;

    // Model update on accepted bytes (ready is expected whenever not DONE).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_last  <= 1'b0;
            m_cnt   <= 0;
            m_run   <= 1'b0;
        end else begin
            m_run <= m_run | (m_state == 4);
            if (bus.in_valid && m_state != 4) begin
                case (m_state)
                    0: begin m_last <= bus.in_data[6]; m_state <= 1; end
                    1: m_state <= 2;
                    2: begin
                        m_cnt   <= (bus.in_data == 8'd0) ? 256 : int'(bus.in_data);
                        m_state <= 3;
                    end
                    3: begin
                        m_cnt <= m_cnt - 1;
                        if (m_cnt == 1) m_state <= m_last ? 4 : 0;
                    end
                    default: m_state <= 0;
                endcase
            end
        end
    end

    // Advance to the next falling edge, check per-cycle invariants, log writes.
    task automatic step_cycle();
        @(negedge clk);
        if (rst_n) begin
            n_tests++;
            if (bus.im_we === 1'b1 && bus.dm_we === 1'b1) begin
                n_fail++;
                $display("FAIL strobe_excl: got im_we=%b dm_we=%b required not both 1", bus.im_we, bus.dm_we);
            end
            n_tests++;
            if (bus.busy !== (m_state >= 1 && m_state <= 3)) begin
                n_fail++;
                $display("FAIL busy_state: got %b required %b (state %0d)", bus.busy, (m_state >= 1 && m_state <= 3), m_state);
            end
            n_tests++;
            if (bus.in_ready !== (m_state != 4)) begin
                n_fail++;
                $display("FAIL in_ready_state: got %b required %b", bus.in_ready, (m_state != 4));
            end
            n_tests++;
            if (bus.cores_run !== m_run) begin
                n_fail++;
                $display("FAIL cores_run_cycle: got %b required %b", bus.cores_run, m_run);
            end
            if (bus.im_we === 1'b1) wr_q.push_back('{1'b0, bus.mem_addr, bus.mem_wdata});
            if (bus.dm_we === 1'b1) wr_q.push_back('{1'b1, bus.mem_addr, bus.mem_wdata});
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        step_cycle();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int k = 0; k < n; k++) step_cycle();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step_cycle();
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({bus.im_we, bus.dm_we, bus.cores_run, bus.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {bus.im_we, bus.dm_we, bus.cores_run, bus.busy});
        end
        n_tests++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h required 00/0000", bus.mem_addr, bus.mem_wdata);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_im_frame();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hCC;
        wr_q.delete();
        send(8'h00); send(8'h10); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        idle(2);
        n_tests++;
        if (wr_q.size() != 3) begin
            n_fail++;
            $display("FAIL im_count: got %0d required 3", wr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (wr_q[i].dm !== 1'b0 || wr_q[i].addr !== 8'h10 + 8'(i) ||
                    wr_q[i].data !== {8'h00, exp_d[i]}) begin
                    n_fail++;
                    $display("FAIL im_write%0d: got dm=%b %h/%h required dm=0 %h/%h", i,
                             wr_q[i].dm, wr_q[i].addr, wr_q[i].data, 8'h10 + 8'(i), {8'h00, exp_d[i]});
                end
            end
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.cores_run !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL im_back_to_hdr: got busy=%b run=%b rdy=%b required 0 0 1", bus.busy, bus.cores_run, bus.in_ready);
        end
    endtask

    task automatic test_dm_wrap();
        logic [7:0] exp_a [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        wr_q.delete();
        send(8'hC0); send(8'hFE); send(8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        n_tests++;
        if (bus.dm_we !== 1'b1 || bus.cores_run !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dm_last_write: got dm_we=%b run=%b rdy=%b required 1 0 0", bus.dm_we, bus.cores_run, bus.in_ready);
        end
        idle(1);
        n_tests++;
        if (bus.cores_run !== 1'b1 || bus.dm_we !== 1'b0) begin
            n_fail++;
            $display("FAIL dm_run_rise: got run=%b dm_we=%b required 1 0", bus.cores_run, bus.dm_we);
        end
        send(8'h77); send(8'h00);
        idle(2);
        n_tests++;
        if (wr_q.size() != 3) begin
            n_fail++;
            $display("FAIL dm_count: got %0d required 3", wr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (wr_q[i].dm !== 1'b1 || wr_q[i].addr !== exp_a[i] ||
                    wr_q[i].data !== 16'h0001 + 16'(i)) begin
                    n_fail++;
                    $display("FAIL dm_write%0d: got dm=%b %h/%h required dm=1 %h/%h", i,
                             wr_q[i].dm, wr_q[i].addr, wr_q[i].data, exp_a[i], 16'h0001 + 16'(i));
                end
            end
        end
        n_tests++;
        if (bus.cores_run !== 1'b1 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0003) begin
            n_fail++;
            $display("FAIL done_hold: got run=%b %h/%h required 1 00/0003", bus.cores_run, bus.mem_addr, bus.mem_wdata);
        end
        do_reset();
    endtask

    task automatic test_gapped();
        wr_q.delete();
        send(8'h00); send(8'h30); send(8'h04);
        for (int i = 0; i < 4; i++) begin
            send(8'hD0 + 8'(i));
            n_tests++;
            if (bus.im_we !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_strobe%0d: got %b required 1", i, bus.im_we);
            end
            idle(1);
            n_tests++;
            if (bus.im_we !== 1'b0 || bus.mem_addr !== 8'h30 + 8'(i)) begin
                n_fail++;
                $display("FAIL gap_idle%0d: got we=%b addr=%h required 0 %h", i, bus.im_we, bus.mem_addr, 8'h30 + 8'(i));
            end
        end
        idle(1);
        n_tests++;
        if (wr_q.size() != 4) begin
            n_fail++;
            $display("FAIL gap_count: got %0d required 4", wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (wr_q[i].addr !== 8'h30 + 8'(i) || wr_q[i].data !== {8'h00, 8'hD0 + 8'(i)}) begin
                    n_fail++;
                    $display("FAIL gap_write%0d: got %h/%h required %h/%h", i,
                             wr_q[i].addr, wr_q[i].data, 8'h30 + 8'(i), {8'h00, 8'hD0 + 8'(i)});
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        wr_q.delete();
        send(8'h80); send(8'h40); send(8'h05);
        send(8'h11); send(8'h22);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.dm_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_clear: got we=%b busy=%b %h/%h required 0 0 00/0000",
                     bus.dm_we, bus.busy, bus.mem_addr, bus.mem_wdata);
        end
        #1 rst_n = 1'b1;
        idle(2);
        n_tests++;
        if (wr_q.size() != 2) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d required 2", wr_q.size());
        end
        send(8'h80); send(8'h20); send(8'h01); send(8'h55);
        idle(2);
        n_tests++;
        if (wr_q.size() != 3 || wr_q[wr_q.size()-1].dm !== 1'b1 ||
            wr_q[wr_q.size()-1].addr !== 8'h20 || wr_q[wr_q.size()-1].data !== 16'h0055) begin
            n_fail++;
            $display("FAIL midrst_next: got n=%0d last=%h/%h required n=3 DM 20/0055",
                     wr_q.size(), wr_q[wr_q.size()-1].addr, wr_q[wr_q.size()-1].data);
        end
        n_tests++;
        if (bus.mem_addr !== 8'h20 || bus.mem_wdata !== 16'h0055 || bus.dm_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold: got %h/%h we=%b required 20/0055 0", bus.mem_addr, bus.mem_wdata, bus.dm_we);
        end
    endtask

    task automatic test_full_256();
        int bad;
        do_reset();
        wr_q.delete();
        send(8'h40); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A);
        n_tests++;
        if (bus.im_we !== 1'b1 || bus.cores_run !== 1'b0) begin
            n_fail++;
            $display("FAIL full_last: got we=%b run=%b required 1 0", bus.im_we, bus.cores_run);
        end
        idle(1);
        n_tests++;
        if (bus.cores_run !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_run: got run=%b rdy=%b required 1 0", bus.cores_run, bus.in_ready);
        end
        send(8'h00); send(8'h10); send(8'h01);
        idle(2);
        n_tests++;
        if (wr_q.size() != 256) begin
            n_fail++;
            $display("FAIL full_count: got %0d required 256", wr_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (wr_q[i].dm !== 1'b0 || wr_q[i].addr !== 8'(i) ||
                    wr_q[i].data !== {8'h00, 8'(i) ^ 8'h5A}) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL full_writes: got %0d bad writes required 0", bad);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_im_frame();
        test_dm_wrap();
        test_gapped();
        test_reset_mid_frame();
        test_full_256();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, memory write-data width; loaded bytes are zero-extended to it.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, host byte valid.
REQ-006 The block SHALL have port in_data, input, 8, host byte.
REQ-007 The block SHALL have port in_ready, output, 1, the loader accepts the byte this cycle.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W, write address shared by both memories.
REQ-009 The block SHALL have port mem_wdata, output, DATA_W, write data shared by both memories.
REQ-010 The block SHALL have port im_we, output, 1, instruction-memory write strobe.
REQ-011 The block SHALL have port dm_we, output, 1, data-memory write strobe.
REQ-012 The block SHALL have port busy, output, 1, a frame is in progress (any state other than HDR or DONE).
REQ-013 The block SHALL have port cores_run, output, 1, release for all cores; high only after the final frame.

Function
REQ-014 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both high; there is no other acceptance.
REQ-015 FSM states SHALL be HDR, ADDR, LEN, DATA, DONE.
REQ-016 Header byte: bit7 target (0 = IM, 1 = DM), bit6 last-frame flag, bits5:0 ignored; HDR -> ADDR on acceptance.
REQ-017 ADDR: accepted byte loads the start address; ADDR -> LEN.
REQ-018 LEN: accepted byte loads the word count N, with 0 meaning 256; LEN -> DATA.
REQ-019 DATA: each accepted byte SHALL produce exactly one write, so the write strobe is high for the single cycle following the accepting edge.
REQ-020 For that write, mem_addr and mem_wdata SHALL carry the current address and {zeros, byte}, registered at the same edge.
REQ-021 The strobe driven in DATA SHALL be im_we if target = 0 and dm_we if target = 1; im_we and dm_we SHALL never be high together.
REQ-022 The address SHALL increment by 1 after each write and wrap from 2^ADDR_W-1 to 0.
REQ-023 After the Nth data byte, the FSM SHALL go to DONE if the last-frame flag was set, else to HDR.
REQ-024 in_ready SHALL be high in HDR, ADDR, LEN and DATA, and low in DONE; it SHALL be combinational from the state only, never from in_valid.
REQ-025 in_valid low in any state SHALL hold all state, address and count; the write strobes SHALL be low.
REQ-026 In DONE, cores_run SHALL be high and remain high until reset; all further input SHALL be ignored.
REQ-027 mem_addr and mem_wdata SHALL hold their last written value when no strobe is active.
REQ-028 A frame with the last-frame flag set and N = 256 SHALL write all 256 locations, then assert cores_run on the cycle after the final write strobe.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state HDR, im_we = 0, dm_we = 0, cores_run = 0, busy = 0, mem_addr = 0 and mem_wdata = 0, with no clock required.
REQ-030 Reset mid-frame SHALL abandon the frame with no further writes; memory contents already written remain.
REQ-031 After rst_n deasserts, the first accepted byte SHALL be treated as a header.

Verification
REQ-032 Frame 0x00, 0x10, 0x03, bytes AA BB CC sent back-to-back -> im_we pulses at addresses 0x10, 0x11, 0x12 with data 0x00AA, 0x00BB, 0x00CC; dm_we stays 0; cores_run stays 0; FSM returns to HDR.
REQ-033 Frame 0xC0, 0xFE, 0x03, bytes 01 02 03 -> dm_we writes at 0xFE, 0xFF, 0x00 (wrap); cores_run rises the cycle after the third write; in_ready is then 0.
REQ-034 in_valid toggled every other cycle during a 4-byte DATA phase -> exactly 4 strobes, addresses consecutive, no strobe on idle cycles.
REQ-035 rst_n pulsed low after the 2nd of 5 data bytes -> strobes stop at once; the next frame 0x80, 0x20, 0x01, 0x55 writes DM 0x20 = 0x0055.
REQ-036 Frame 0x40, 0x00, 0x00 followed by 256 bytes -> 256 im_we pulses at addresses 0x00..0xFF; cores_run = 1 afterwards; extra bytes sent after that are not accepted.
REQ-037 The bench SHALL check on every cycle that im_we and dm_we are never high together and that busy matches the FSM state.
